hazard3_sbus_arbiter: RTL and testbench

- Shares one downstream System Bus Access port between N_PORTS upstream sbus requesters, e.g. DM SBA plus a DMA or trace agent.
- The downstream port feeds the sbus-to-AHB shim.
- Arbitration is round-robin.
- A grant is locked from the first cycle a request is presented downstream until that transfer completes, so addr/size/write/wdata stay stable for the whole transfer as the sbus protocol requires.

---
 rtl/hazard3_sbus_arbiter.sv | 99 +++++++++
 tb/tb_hazard3_sbus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_sbus_arbiter.sv
// Round-robin arbiter sharing one downstream sbus port between N_PORTS requesters.
// Latency: zero; an idle arbiter forwards a request to dn_vld in the same cycle.
// Backpressure: the grant locks until dn_rdy, and losing ports hold vld until their own up_rdy.
// Ports: clk/rst (sync, active-high); up_* packed per-port request and response bundles;
//        dn_* single downstream request and response toward the sbus-to-AHB shim.
module hazard3_sbus_arbiter #(
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter int N_PORTS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTS*W_ADDR-1:0]   up_addr,
   input  logic [N_PORTS-1:0]          up_write,
   input  logic [N_PORTS*2-1:0]        up_size,
   input  logic [N_PORTS-1:0]          up_vld,
   output logic [N_PORTS-1:0]          up_rdy,
   output logic [N_PORTS-1:0]          up_err,
   input  logic [N_PORTS*W_DATA-1:0]   up_wdata,
   output logic [W_DATA-1:0]           up_rdata,
   output logic [W_ADDR-1:0]           dn_addr,
   output logic                        dn_write,
   output logic [1:0]                  dn_size,
   output logic                        dn_vld,
   input  logic                        dn_rdy,
   input  logic                        dn_err,
   output logic [W_DATA-1:0]           dn_wdata,
   input  logic [W_DATA-1:0]           dn_rdata
);

   localparam int W_IDX = $clog2(N_PORTS);

   logic             r_locked;
   logic [W_IDX-1:0] r_grant;
   logic [W_IDX-1:0] r_last;

   logic [W_IDX-1:0] w_pick;
   logic [W_IDX-1:0] w_sel;

   // Round-robin search starting just after the last completed port. Offsets are
   // scanned from farthest to nearest so the nearest requesting port wins; offset
   // N_PORTS is the last port itself, which therefore has the lowest priority.
   always_comb begin
      w_pick = (r_last == W_IDX'(N_PORTS - 1)) ? '0 : r_last + 1'b1;
      for (int k = N_PORTS; k >= 1; k--) begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (up_vld[i] && (i == (int'(r_last) + k) % N_PORTS)) begin
               w_pick = W_IDX'(i);
            end
         end
      end
   end

   // Once a transfer has been presented, the grant is frozen so the payload
   // stays stable even if the requester misbehaves and drops vld.
   assign w_sel  = r_locked ? r_grant : w_pick;
   assign dn_vld = r_locked | (|up_vld);

   always_comb begin
      dn_addr  = '0;
      dn_write = 1'b0;
      dn_size  = 2'b00;
      dn_wdata = '0;
      up_rdy   = '0;
      up_err   = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (w_sel == W_IDX'(i)) begin
            dn_addr  = up_addr[i*W_ADDR +: W_ADDR];
            dn_write = up_write[i];
            dn_size  = up_size[i*2 +: 2];
            dn_wdata = up_wdata[i*W_DATA +: W_DATA];
            // Masked in reset so no completion can leak out while state is being cleared.
            up_rdy[i] = dn_rdy & dn_vld & ~rst;
            up_err[i] = dn_rdy & dn_vld & ~rst & dn_err;
         end
      end
   end

   assign up_rdata = dn_rdata;

   // Completion takes priority over locking; a stray dn_rdy with dn_vld low
   // falls through both branches and leaves the state untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_locked <= 1'b0;
         r_grant  <= '0;
         r_last   <= W_IDX'(N_PORTS - 1);
      end else if (dn_vld) begin
         if (dn_rdy) begin
            r_locked <= 1'b0;
            r_last   <= w_sel;
         end else begin
            r_locked <= 1'b1;
            r_grant  <= w_sel;
         end
      end
   end

endmodule

// File: tb/tb_hazard3_sbus_arbiter.sv
module tb_hazard3_sbus_arbiter;

   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*32-1:0] up_addr;
   logic [N-1:0]    up_write;
   logic [N*2-1:0]  up_size;
   logic [N-1:0]    up_vld;
   logic [N-1:0]    up_rdy;
   logic [N-1:0]    up_err;
   logic [N*32-1:0] up_wdata;
   logic [31:0]     up_rdata;
   logic [31:0]     dn_addr;
   logic            dn_write;
   logic [1:0]      dn_size;
   logic            dn_vld;
   logic            dn_rdy;
   logic            dn_err;
   logic [31:0]     dn_wdata;
   logic [31:0]     dn_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [31:0] A0 = 32'h1000_0010;
   localparam logic [31:0] A1 = 32'h2000_0004;

   hazard3_sbus_arbiter #(.W_ADDR(32), .W_DATA(32), .N_PORTS(N)) dut (
      .clk(clk), .rst(rst),
      .up_addr(up_addr), .up_write(up_write), .up_size(up_size), .up_vld(up_vld),
      .up_rdy(up_rdy), .up_err(up_err), .up_wdata(up_wdata), .up_rdata(up_rdata),
      .dn_addr(dn_addr), .dn_write(dn_write), .dn_size(dn_size), .dn_vld(dn_vld),
      .dn_rdy(dn_rdy), .dn_err(dn_err), .dn_wdata(dn_wdata), .dn_rdata(dn_rdata)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are then driven and
   // outputs sampled 1 time unit later, well clear of the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; up_vld = '0; dn_rdy = 1'b0; dn_err = 1'b0; dn_rdata = '0;
      up_addr = {A1, A0}; up_write = '0; up_size = {2'd2, 2'd2}; up_wdata = '0;
      tick(); tick(); #1;
      n_cmp++; if (dn_vld !== 1'b0) begin n_bad++; $display("FAIL reset_dn_vld: got %b want 0", dn_vld); end
      n_cmp++; if (up_rdy !== 2'b00) begin n_bad++; $display("FAIL reset_up_rdy: got %b want 00", up_rdy); end
      up_vld = 2'b11; dn_rdy = 1'b1; #1;
      n_cmp++; if (dn_vld !== 1'b1) begin n_bad++; $display("FAIL reset_vld_follow: got %b want 1", dn_vld); end
      n_cmp++; if (dn_addr !== A0) begin n_bad++; $display("FAIL reset_prio: got %h want %h", dn_addr, A0); end
      n_cmp++; if (up_rdy !== 2'b00 || up_err !== 2'b00) begin n_bad++; $display("FAIL reset_no_rdy: got %b/%b want 00/00", up_rdy, up_err); end
      tick(); rst = 1'b0; up_vld = '0; dn_rdy = 1'b0;
   endtask

   task automatic test_single();
      tick();
      up_vld = 2'b10; up_write = 2'b00; up_size = {2'd2, 2'd0};
      for (int c = 0; c < 4; c++) begin
         dn_rdy = (c == 3); dn_rdata = (c == 3) ? 32'hCAFE_F00D : 32'h0;
         #1;
         n_cmp++; if (dn_vld !== 1'b1 || dn_addr !== A1) begin n_bad++; $display("FAIL single_c%0d_addr: got %b/%h want 1/%h", c, dn_vld, dn_addr, A1); end
         n_cmp++; if (up_rdy !== ((c == 3) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL single_c%0d_rdy: got %b", c, up_rdy); end
         if (c == 3) begin
            n_cmp++; if (up_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL single_rdata: got %h want cafef00d", up_rdata); end
            n_cmp++; if (dn_size !== 2'd2) begin n_bad++; $display("FAIL single_size: got %0d want 2", dn_size); end
         end
         tick();
      end
      up_vld = '0; dn_rdy = 1'b0; #1;
      n_cmp++; if (dn_vld !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", dn_vld); end
   endtask

   // Last completed port is 1 here, so port 0 is served first.
   task automatic test_alternate();
      logic [31:0] want;
      up_vld = 2'b11;
      for (int t = 0; t < 4; t++) begin
         want = (t % 2 == 0) ? A0 : A1;
         for (int c = 0; c < 2; c++) begin
            dn_rdy = (c == 1); #1;
            n_cmp++; if (dn_vld !== 1'b1 || dn_addr !== want) begin n_bad++; $display("FAIL alt_t%0d_c%0d: got %b/%h want 1/%h", t, c, dn_vld, dn_addr, want); end
            n_cmp++; if (up_rdy !== ((c == 1) ? 2'(1 << (t % 2)) : 2'b00)) begin n_bad++; $display("FAIL alt_rdy_t%0d_c%0d: got %b", t, c, up_rdy); end
            tick();
         end
      end
      up_vld = '0; dn_rdy = 1'b0;
   endtask

   task automatic test_lock();
      up_vld = 2'b01; dn_rdy = 1'b0; #1;
      n_cmp++; if (dn_addr !== A0) begin n_bad++; $display("FAIL lock_c0: got %h want %h", dn_addr, A0); end
      tick(); up_vld = 2'b11; #1;
      n_cmp++; if (dn_addr !== A0) begin n_bad++; $display("FAIL lock_c1: got %h want %h", dn_addr, A0); end
      tick(); dn_rdy = 1'b1; #1;
      n_cmp++; if (dn_addr !== A0 || up_rdy !== 2'b01) begin n_bad++; $display("FAIL lock_c2: got %h/%b want %h/01", dn_addr, up_rdy, A0); end
      tick(); up_vld = 2'b10; dn_rdy = 1'b0; #1;
      n_cmp++; if (dn_vld !== 1'b1 || dn_addr !== A1) begin n_bad++; $display("FAIL lock_next: got %b/%h want 1/%h", dn_vld, dn_addr, A1); end
      tick(); dn_rdy = 1'b1; #1;
      n_cmp++; if (up_rdy !== 2'b10) begin n_bad++; $display("FAIL lock_done: got %b want 10", up_rdy); end
      tick(); up_vld = '0; dn_rdy = 1'b0;
   endtask

   task automatic test_error();
      up_vld = 2'b10; up_write = 2'b10; up_wdata = {32'h1234_5678, 32'hDEAD_BEEF}; #1;
      n_cmp++; if (dn_write !== 1'b1 || dn_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL err_payload: got %b/%h want 1/12345678", dn_write, dn_wdata); end
      tick(); dn_rdy = 1'b1; dn_err = 1'b1; #1;
      n_cmp++; if (up_err !== 2'b10 || up_rdy !== 2'b10) begin n_bad++; $display("FAIL err_route: got err=%b rdy=%b want 10/10", up_err, up_rdy); end
      tick(); up_vld = 2'b01; up_write = '0; dn_rdy = 1'b0; dn_err = 1'b0; #1;
      n_cmp++; if (up_err !== 2'b00 || dn_addr !== A0) begin n_bad++; $display("FAIL err_unlock: got err=%b addr=%h want 00/%h", up_err, dn_addr, A0); end
      tick(); dn_rdy = 1'b1; #1;
      n_cmp++; if (up_rdy !== 2'b01) begin n_bad++; $display("FAIL err_next_done: got %b want 01", up_rdy); end
      tick(); up_vld = '0; dn_rdy = 1'b0;
   endtask

   // Last completed port is 0 after test_error.
   task automatic test_withdraw();
      up_vld = 2'b01; tick();
      up_vld = 2'b00; #1;
      n_cmp++; if (dn_vld !== 1'b1 || dn_addr !== A0) begin n_bad++; $display("FAIL wd_hold: got %b/%h want 1/%h", dn_vld, dn_addr, A0); end
      tick(); dn_rdy = 1'b1; #1;
      n_cmp++; if (up_rdy !== 2'b01) begin n_bad++; $display("FAIL wd_rdy: got %b want 01", up_rdy); end
      tick(); dn_rdy = 1'b0; #1;
      n_cmp++; if (dn_vld !== 1'b0) begin n_bad++; $display("FAIL wd_release: got %b want 0", dn_vld); end
      tick(); dn_rdy = 1'b1; #1;
      n_cmp++; if (up_rdy !== 2'b00 || dn_vld !== 1'b0) begin n_bad++; $display("FAIL stray_rdy: got rdy=%b vld=%b want 00/0", up_rdy, dn_vld); end
      tick(); dn_rdy = 1'b0; up_vld = 2'b11; #1;
      n_cmp++; if (dn_addr !== A1) begin n_bad++; $display("FAIL stray_state: got %h want %h", dn_addr, A1); end
      tick(); dn_rdy = 1'b1; tick(); dn_rdy = 1'b0; up_vld = '0;
   endtask

   task automatic test_midreset();
      up_vld = 2'b10; tick();
      up_vld = 2'b11; #1;
      n_cmp++; if (dn_addr !== A1) begin n_bad++; $display("FAIL mr_locked: got %h want %h", dn_addr, A1); end
      rst = 1'b1; tick(); rst = 1'b0; #1;
      n_cmp++; if (dn_addr !== A0 || up_rdy !== 2'b00) begin n_bad++; $display("FAIL mr_after: got %h/%b want %h/00", dn_addr, up_rdy, A0); end
      tick(); dn_rdy = 1'b1; #1;
      n_cmp++; if (up_rdy !== 2'b01) begin n_bad++; $display("FAIL mr_done: got %b want 01", up_rdy); end
      tick(); up_vld = '0; dn_rdy = 1'b0;
   endtask

   // Reference: an owner is the port whose transfer has been presented and not
   // yet completed; otherwise the next pending port after the last served one.
   task automatic test_random();
      int          owner;
      int          last;
      int          sel;
      bit          pend [N];
      logic [31:0] a    [N];
      logic [31:0] wd   [N];
      bit          wr   [N];
      logic [1:0]  sz   [N];
      bit          any;
      rst = 1'b1; up_vld = '0; dn_rdy = 1'b0; tick(); rst = 1'b0;
      owner = -1; last = N - 1;
      for (int i = 0; i < N; i++) pend[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(2) == 0)) begin
               pend[i] = 1; a[i] = $urandom; wd[i] = $urandom;
               wr[i] = 1'($urandom_range(1)); sz[i] = 2'($urandom_range(2));
            end
            up_vld[i] = pend[i]; up_addr[i*32 +: 32] = a[i]; up_wdata[i*32 +: 32] = wd[i];
            up_write[i] = wr[i]; up_size[i*2 +: 2] = sz[i];
         end
         any = 0;
         for (int i = 0; i < N; i++) any |= pend[i];
         sel = owner;
         if (owner < 0) begin
            for (int k = 1; k <= N && sel < 0; k++)
               if (pend[(last + k) % N]) sel = (last + k) % N;
         end
         dn_rdy = (owner >= 0) && ($urandom_range(1) == 1);
         dn_err = 1'($urandom_range(1)); dn_rdata = $urandom;
         #1;
         n_cmp++; if (dn_vld !== (owner >= 0 || any)) begin n_bad++; $display("FAIL rnd_vld cyc%0d: got %b", cyc, dn_vld); end
         if (sel >= 0) begin
            n_cmp++;
            if (dn_addr !== a[sel] || dn_wdata !== wd[sel] || dn_write !== wr[sel] || dn_size !== sz[sel]) begin
               n_bad++; $display("FAIL rnd_payload cyc%0d: got %h want %h (port %0d)", cyc, dn_addr, a[sel], sel);
            end
            n_cmp++;
            if (up_rdy !== (dn_rdy ? 2'(1 << sel) : 2'b00) || up_err !== ((dn_rdy && dn_err) ? 2'(1 << sel) : 2'b00)) begin
               n_bad++; $display("FAIL rnd_resp cyc%0d: got rdy=%b err=%b port %0d", cyc, up_rdy, up_err, sel);
            end
            n_cmp++; if (up_rdata !== dn_rdata) begin n_bad++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, up_rdata, dn_rdata); end
            if (dn_rdy) begin owner = -1; last = sel; pend[sel] = 0; end
            else owner = sel;
         end
         tick();
      end
      up_vld = '0; dn_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_lock();
      test_error();
      test_withdraw();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
